// File: rtl/sevenseg_scan_driver_if.sv
// Display-side bundle for the multiplexed seven-segment scan driver.
// The master drives the display content and enable; the slave returns the scan outputs.
interface sevenseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic                    lzs;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;

    modport master (
        output en, load, data, dp_in, blank_in, blink_in, lzs,
        input  seg, dp, an, digit_idx, frame_done
    );

    modport slave (
        input  en, load, data, dp_in, blank_in, blink_in, lzs,
        output seg, dp, an, digit_idx, frame_done
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment scanner: shadowed display content, prescaled digit
// rotation, per-digit blank/blink, leading-zero suppression, registered active-low outputs.
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    sevenseg_scan_driver_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = $clog2(REFRESH_DIV);
    localparam int BL_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [4*NUM_DIGITS-1:0] sh_data;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_blank, sh_blink;
    logic                    sh_lzs;

    logic [PS_W-1:0]       presc;
    logic [IDX_W-1:0]      idx, idx_nxt, r_idx;
    logic [BL_W-1:0]       blink_cnt;
    logic                  blink_phase;
    logic                  live, paused;
    logic                  tick, wrap;

    logic [6:0]            seg_q, r_seg;
    logic                  dp_q, r_dp;
    logic [NUM_DIGITS-1:0] an_q, r_an;
    logic                  frame_q;

    logic [NUM_DIGITS-1:0] supp;
    logic                  zero_run;
    logic [3:0]            nib;
    logic                  dark;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign tick    = bus.en && (presc == PS_W'(REFRESH_DIV - 1));
    assign wrap    = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    assign idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);

    // A digit is suppressed only while it and every digit above it hold zero.
    always_comb begin
        supp     = '0;
        zero_run = sh_lzs;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (sh_data[4*k +: 4] == 4'h0);
            supp[k]  = zero_run;
        end
    end

    // Render the slot about to be shown; blink_phase and shadows are the pre-edge values.
    always_comb begin
        r_idx = tick ? idx_nxt : idx;
        nib   = sh_data[{r_idx, 2'b00} +: 4];
        dark  = sh_blank[r_idx] || (sh_blink[r_idx] && blink_phase) || supp[r_idx];
        r_seg = dark ? 7'h7F : glyph(nib);
        r_dp  = dark || !sh_dp[r_idx];
        for (int k = 0; k < NUM_DIGITS; k++)
            r_an[k] = (r_idx != IDX_W'(k));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_data     <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_blink    <= '0;
            sh_lzs      <= 1'b0;
            presc       <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            live        <= 1'b0;
            paused      <= 1'b0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= '1;
            frame_q     <= 1'b0;
        end else begin
            if (bus.load) begin
                sh_data  <= bus.data;
                sh_dp    <= bus.dp_in;
                sh_blank <= bus.blank_in;
                sh_blink <= bus.blink_in;
                sh_lzs   <= bus.lzs;
            end
            frame_q <= wrap;
            if (bus.en) begin
                presc  <= tick ? '0 : presc + PS_W'(1);
                paused <= 1'b0;
                if (tick) begin
                    idx  <= idx_nxt;
                    live <= 1'b1;
                    if (blink_cnt == BL_W'(BLINK_TICKS - 1)) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        blink_cnt <= blink_cnt + BL_W'(1);
                    end
                end
                // Coming back from a pause redraws the held digit without waiting for a tick.
                if (tick || (paused && live)) begin
                    seg_q <= r_seg;
                    dp_q  <= r_dp;
                    an_q  <= r_an;
                end
            end else begin
                paused <= 1'b1;
                seg_q  <= 7'h7F;
                dp_q   <= 1'b1;
                an_q   <= '1;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.digit_idx  = idx;
    assign bus.frame_done = frame_q;
endmodule
